// File: rtl/fetch_unit.sv
// Fetch stage: two-phase fetch/execute sequencer holding the PC, the fetch register and the ALU flags.
// Latency: all outputs are registered; every request takes effect on the next active clock edge.
// Backpressure: none; enable=0 freezes all state for as long as it is held low.
module fetch_unit #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [7:0]        program_byte,
   input  logic              incPC,
   input  logic              loadPC,
   input  logic              loadFlags,
   input  logic              c_in,
   input  logic              z_in,
   output logic [ADDR_W-1:0] pc,
   output logic              phase,
   output logic [3:0]        instr,
   output logic [3:0]        oprnd,
   output logic              c_flag,
   output logic              z_flag
);

   typedef enum logic {
      FETCH   = 1'b0,
      EXECUTE = 1'b1
   } phase_t;

   // Opcode in the high nibble, operand in the low nibble, as stored in program memory.
   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] operand;
   } fetchReg_t;

   phase_t            phaseReg, phaseNext;
   fetchReg_t         fetchReg, fetchNext;
   logic [ADDR_W-1:0] pcReg, pcNext;
   logic [11:0]       jumpTarget;
   logic              cReg, cNext;
   logic              zReg, zNext;

   // Next-state logic: phase toggles, fetch register loads only in the fetch phase,
   // jump beats increment, flags capture on request; nothing moves without enable.
   always_comb begin
      phaseNext  = phaseReg;
      fetchNext  = fetchReg;
      pcNext     = pcReg;
      cNext      = cReg;
      zNext      = zReg;
      // Jump target uses the operand latched in the fetch phase plus the byte now on the bus.
      jumpTarget = {fetchReg.operand, program_byte};
      if (enable) begin
         if (phaseReg == FETCH) begin
            phaseNext = EXECUTE;
            fetchNext = fetchReg_t'(program_byte);
         end else begin
            phaseNext = FETCH;
         end
         if (loadPC) begin
            pcNext = ADDR_W'(jumpTarget);
         end else if (incPC) begin
            pcNext = pcReg + ADDR_W'(1);
         end
         if (loadFlags) begin
            cNext = c_in;
            zNext = z_in;
         end
      end
   end

   // State registers; reset clears everything immediately, discarding any in-flight instruction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phaseReg <= FETCH;
         fetchReg <= '0;
         pcReg    <= RESET_PC;
         cReg     <= 1'b0;
         zReg     <= 1'b0;
      end else begin
         phaseReg <= phaseNext;
         fetchReg <= fetchNext;
         pcReg    <= pcNext;
         cReg     <= cNext;
         zReg     <= zNext;
      end
   end

   assign pc     = pcReg;
   assign phase  = phaseReg;
   assign instr  = fetchReg.opcode;
   assign oprnd  = fetchReg.operand;
   assign c_flag = cReg;
   assign z_flag = zReg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [7:0]  program_byte;
   logic        incPC;
   logic        loadPC;
   logic        loadFlags;
   logic        c_in;
   logic        z_in;
   logic [11:0] pc;
   logic        phase;
   logic [3:0]  instr;
   logic [3:0]  oprnd;
   logic        c_flag;
   logic        z_flag;

   int total = 0;
   int bad   = 0;

   fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
      .clock(clock), .reset(reset), .enable(enable), .program_byte(program_byte),
      .incPC(incPC), .loadPC(loadPC), .loadFlags(loadFlags), .c_in(c_in), .z_in(z_in),
      .pc(pc), .phase(phase), .instr(instr), .oprnd(oprnd), .c_flag(c_flag), .z_flag(z_flag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One active edge, then settle 1 time unit past it before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [7:0] b, input logic inc, input logic ld,
                        input logic lf, input logic c, input logic z);
      program_byte = b; incPC = inc; loadPC = ld; loadFlags = lf; c_in = c; z_in = z;
   endtask

   task automatic test_reset();
      #2;
      total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h want=000", pc); end
      total++; if (phase !== 1'b0) begin bad++; $display("FAIL reset_phase got=%b want=0", phase); end
      total++; if ({instr, oprnd} !== 8'h00) begin bad++; $display("FAIL reset_fetch got=%h want=00", {instr, oprnd}); end
      total++; if ({c_flag, z_flag} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {c_flag, z_flag}); end
      // Reset must dominate active edges with enable and requests applied.
      enable = 1'b1;
      drive(8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      step();
      total++; if ({pc, phase, instr, c_flag, z_flag} !== {12'h000, 1'b0, 4'h0, 2'b00})
         begin bad++; $display("FAIL reset_hold got=%h/%b/%h/%b%b want=000/0/0/00", pc, phase, instr, c_flag, z_flag); end
      drive(8'h4A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #3 reset = 1'b0;
   endtask

   task automatic test_fetch();
      step();
      total++; if ({instr, oprnd} !== 8'h4A) begin bad++; $display("FAIL fetch_reg got=%h want=4a", {instr, oprnd}); end
      total++; if (phase !== 1'b1 || pc !== 12'h001) begin bad++; $display("FAIL fetch_c1 got=%b/%h want=1/001", phase, pc); end
      step();
      total++; if (pc !== 12'h002 || phase !== 1'b0) begin bad++; $display("FAIL fetch_c2 got=%h/%b want=002/0", pc, phase); end
   endtask

   task automatic test_jump();
      drive(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      total++; if ({instr, oprnd} !== 8'hC3 || pc !== 12'h003) begin bad++; $display("FAIL jump_fetch got=%h/%h want=c3/003", {instr, oprnd}, pc); end
      drive(8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      total++; if (pc !== 12'h37F) begin bad++; $display("FAIL jump_pc got=%h want=37f", pc); end
      total++; if (instr !== 4'hC || oprnd !== 4'h3 || phase !== 1'b0) begin bad++; $display("FAIL jump_hold got=%h%h/%b want=c3/0", instr, oprnd, phase); end
   endtask

   task automatic test_wrap();
      drive(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      total++; if (pc !== 12'h37F || oprnd !== 4'hF) begin bad++; $display("FAIL wrap_idle got=%h/%h want=37f/f", pc, oprnd); end
      drive(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      total++; if (pc !== 12'hFFF) begin bad++; $display("FAIL wrap_setup got=%h want=fff", pc); end
      drive(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      total++; if (pc !== 12'h000) begin bad++; $display("FAIL wrap_pc got=%h want=000", pc); end
      total++; if ({instr, oprnd} !== 8'h12) begin bad++; $display("FAIL wrap_fetch got=%h want=12", {instr, oprnd}); end
   endtask

   task automatic test_jump_wins();
      drive(8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      total++; if (pc !== 12'h210) begin bad++; $display("FAIL jump_wins got=%h want=210", pc); end
      total++; if ({instr, oprnd} !== 8'h12 || phase !== 1'b0) begin bad++; $display("FAIL exec_hold got=%h/%b want=12/0", {instr, oprnd}, phase); end
   endtask

   task automatic test_flags();
      drive(8'h5E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      total++; if ({c_flag, z_flag} !== 2'b00) begin bad++; $display("FAIL flags_comb got=%b%b want=00", c_flag, z_flag); end
      step();
      total++; if ({c_flag, z_flag} !== 2'b10 || pc !== 12'h211) begin bad++; $display("FAIL flags_cap got=%b%b/%h want=10/211", c_flag, z_flag, pc); end
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      total++; if ({c_flag, z_flag} !== 2'b10) begin bad++; $display("FAIL flags_hold got=%b%b want=10", c_flag, z_flag); end
      enable = 1'b0;
      drive(8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();
      total++; if ({pc, phase, c_flag, z_flag} !== {12'h211, 1'b0, 2'b10})
         begin bad++; $display("FAIL enable_hold got=%h/%b/%b%b want=211/0/10", pc, phase, c_flag, z_flag); end
      total++; if ({instr, oprnd} !== 8'h5E) begin bad++; $display("FAIL enable_fetch got=%h want=5e", {instr, oprnd}); end
      enable = 1'b1;
      drive(8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      total++; if ({c_flag, z_flag} !== 2'b01 || {instr, oprnd} !== 8'h99 || phase !== 1'b1)
         begin bad++; $display("FAIL flags_z got=%b%b/%h/%b want=01/99/1", c_flag, z_flag, {instr, oprnd}, phase); end
   endtask

   task automatic test_async_reset();
      // Execute cycle in progress; assert reset between edges.
      drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      total++; if ({pc, phase, instr, oprnd, c_flag, z_flag} !== {12'h000, 1'b0, 8'h00, 2'b00})
         begin bad++; $display("FAIL async_reset got=%h/%b/%h%h/%b%b want=000/0/00/00", pc, phase, instr, oprnd, c_flag, z_flag); end
      drive(8'hB6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      step();
      total++; if (phase !== 1'b1 || {instr, oprnd} !== 8'hB6 || pc !== 12'h000)
         begin bad++; $display("FAIL post_reset got=%b/%h/%h want=1/b6/000", phase, {instr, oprnd}, pc); end
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_fetch();
      test_jump();
      test_wrap();
      test_jump_wins();
      test_flags();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
